vmask_first_scan: RTL and testbench
===================================

# vmask_first_scan

Multi-beat mask scanner for the vector ALU. It is the parametrised successor to the single-beat find-first-set unit. It streams a mask register through the datapath one `DATA_WIDTH`-bit beat at a time and implements four RVV mask operations: `vfirst.m`, `vmsbf.m`, `vmsif.m` and `vmsof.m`. A "found" state and an element-index base carry across beats, and element masking with undisturbed inactive elements is supported. It sits beside the other vALU mask units and drives the ALU writeback mux.

## Interface
- `DATA_WIDTH`, 64: mask bits (elements) per beat. Must be a power of 2 and ≥ `IDX_BITS`.
- `IDX_BITS`, 10: width of the element index and base counter. Must cover the maximum vector length in elements.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  beat present. There is no backpressure: every valid beat is accepted.
- `in_start`  in  1  first beat of an operation. Qualified by `in_valid`.
- `in_last`  in  1  final beat of an operation. Qualified by `in_valid`. May coincide with `in_start`.
- `in_mode`  in  2  operation select: 0 FIRST, 1 SBF, 2 SIF, 3 SOF. Sampled only on start beats.
- `in_m0`  in  `DATA_WIDTH`  source mask beat (vs2).
- `in_act`  in  `DATA_WIDTH`  active-element mask for this beat. It is v0 ANDed with the body (non-tail) region, precomputed upstream.
- `in_old`  in  `DATA_WIDTH`  old vd beat, used for inactive elements.
- `out_valid`  out  1  result beat valid.
- `out_vec`  out  `DATA_WIDTH`  result beat (mask modes), or the index zero-extended / all-ones (FIRST).
- `out_found`  out  1  FIRST mode only: a set active bit was found.
- `out_last`  out  1  this result is the final one of the operation.

## Operation
- Effective bits per beat: `e = in_m0 & in_act`; `low = e & (~e + 1)`, which isolates the lowest set bit.
- State registers:
  - `mode_q` (2 bits).
  - `found_q`.
  - `base_q` (`IDX_BITS`): element index of bit 0 of the current beat.
  - `idx_q` (`IDX_BITS`): first index found.
- Effective state for a beat: on a start beat, use `found = 0`, `base = 0` and `mode = in_mode`; otherwise use the registers.
- After each valid beat:
  - `base_q` ← `base + DATA_WIDTH`, wrapping modulo 2^`IDX_BITS`.
  - `found_q` ← `found | (e != 0)`.
  - If `!found && e != 0`, `idx_q` ← `base + ctz(e)`.
- A start beat arriving mid-operation aborts the previous operation without emitting a result. State is reinitialised as above.
- Mask modes (SBF, SIF, SOF) compute a raw result `r` per beat:
  - If `found` is set: `r = 0` for all modes.
  - Else if `e == 0`: SBF = all-ones, SIF = all-ones, SOF = 0.
  - Else: SBF = `low - 1`, SIF = `(low - 1) | low`, SOF = `low`.
  - Output: `out_vec = (r & in_act) | (in_old & ~in_act)`.
  - `out_valid` is asserted for every beat; `out_last` = `in_last`; `out_found` = 0.
- FIRST mode:
  - No output on non-last beats (`out_valid` = 0).
  - On the last beat: `out_valid` = 1 and `out_last` = 1.
  - `out_found` = `found | (e != 0)`.
  - `out_vec` = the zero-extended first index if found, otherwise all-ones (−1).
  - The first index is `idx_q` if `found` was already set, else `base + ctz(e)`.
- In FIRST mode, `in_old` is ignored.

## Timing
- Fully pipelined, with 1-cycle latency: a beat accepted at edge N produces outputs registered at edge N, visible during cycle N+1. Throughput is one beat per cycle.
- When no beat is accepted, all outputs are registered to 0 on the next edge.
- Reset: `out_valid`, `out_vec`, `out_found`, `out_last`, `found_q`, `base_q`, `idx_q` and `mode_q` all become 0. Reset has priority over `in_valid`.
  - Reset mid-operation abandons that operation.
  - The next operation must begin with `in_start`. A non-start beat after reset is processed with `base = 0`, `found = 0` and `mode = FIRST`.
- Simultaneous `in_start` and `in_last` forms a single-beat operation whose result follows one cycle later.
- Beats after `in_last` without an `in_start` continue from the held state; this is a legal but undefined use.

## Test plan
All scenarios use `DATA_WIDTH`=64, `IDX_BITS`=10, and `in_act` all-ones unless stated.

1. FIRST, single beat, start+last, `in_m0`=`0x0100_0000` → next cycle `out_valid`=1, `out_vec`=24, `out_found`=1, `out_last`=1.
2. FIRST, 3 beats with `in_m0` = 0, then `1<<5`, then `1<<0` → `out_valid` low after beats 0 and 1. After beat 2: `out_vec`=69, `out_found`=1.
3. FIRST, 2 zero beats → `out_vec`=`0xFFFF_FFFF_FFFF_FFFF`, `out_found`=0. Then a new start beat with `in_m0`=`0x8`, last → `out_vec`=3, which proves the base resets.
4. SIF, 2 beats with `in_m0` = `0x10`, then `0x1` → `out_vec` = `0x1F`, then 0. Repeated as SBF → `0x0F`, then 0.
5. SOF, masked: `in_m0`=`0x6`, `in_act`=`0xFFFF_FFFF_FFFF_FFFD`, `in_old`=`0x2` → `out_vec`=`0x6` (found bit 2, plus undisturbed bit 1).
6. Reset mid-op: an SBF start beat with `in_m0`=`0x8`, then `rst` for 1 cycle → all outputs 0. Then FIRST start+last with `in_m0`=0 → `out_vec` all-ones, `out_found`=0.

Source files
------------

// File: rtl/vmask_first_scan.sv
// Multi-beat mask scanner: vfirst.m, vmsbf.m, vmsif.m, vmsof.m.
// Found flag and element-index base carry across beats.
module vmask_first_scan #(
  parameter int DATA_WIDTH = 64,
  parameter int IDX_BITS   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_start,
  input  logic                  in_last,
  input  logic [1:0]            in_mode,
  input  logic [DATA_WIDTH-1:0] in_m0,
  input  logic [DATA_WIDTH-1:0] in_act,
  input  logic [DATA_WIDTH-1:0] in_old,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_vec,
  output logic                  out_found,
  output logic                  out_last
);

  localparam logic [1:0] MODE_FIRST = 2'd0;
  localparam logic [1:0] MODE_SBF   = 2'd1;
  localparam logic [1:0] MODE_SIF   = 2'd2;
  localparam logic [1:0] MODE_SOF   = 2'd3;

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
  localparam logic [IDX_BITS-1:0] STEP = IDX_BITS'(DATA_WIDTH);

  logic [1:0]            mode_q;
  logic                  found_q;
  logic [IDX_BITS-1:0]   base_q;
  logic [IDX_BITS-1:0]   idx_q;

  logic [DATA_WIDTH-1:0] e;
  logic [DATA_WIDTH-1:0] low;
  logic                  any;
  logic [1:0]            cur_mode;
  logic                  cur_found;
  logic [IDX_BITS-1:0]   cur_base;
  logic [IDX_BITS-1:0]   ctz;
  logic [IDX_BITS-1:0]   hit_idx;
  logic [IDX_BITS-1:0]   first_idx;
  logic [DATA_WIDTH-1:0] r;

  logic                  valid_d;
  logic [DATA_WIDTH-1:0] vec_d;
  logic                  found_d;
  logic                  last_d;

  // Effective bits and the state this beat sees (start beats restart)
  always_comb begin
    e   = in_m0 & in_act;
    low = e & (~e + ONE);
    any = |e;
    if (in_start) begin
      cur_mode  = in_mode;
      cur_found = 1'b0;
      cur_base  = '0;
    end else begin
      cur_mode  = mode_q;
      cur_found = found_q;
      cur_base  = base_q;
    end
  end

  // Count trailing zeros of the effective bits
  always_comb begin
    ctz = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (e[i]) ctz = IDX_BITS'(i);
    end
  end

  // Element index of the first hit, old or new
  always_comb begin
    hit_idx   = cur_base + ctz;
    first_idx = cur_found ? idx_q : hit_idx;
  end

  // Per-beat result for the selected operation
  always_comb begin
    valid_d = 1'b0;
    vec_d   = '0;
    found_d = 1'b0;
    last_d  = 1'b0;
    r       = '0;
    if (in_valid) begin
      if (cur_found) begin
        r = '0;
      end else if (!any) begin
        r = (cur_mode == MODE_SOF) ? '0 : '1;
      end else begin
        unique case (cur_mode)
          MODE_SBF: r = low - ONE;
          MODE_SIF: r = (low - ONE) | low;
          MODE_SOF: r = low;
          default:  r = '0;
        endcase
      end
      if (cur_mode == MODE_FIRST) begin
        if (in_last) begin
          valid_d = 1'b1;
          last_d  = 1'b1;
          found_d = cur_found | any;
          vec_d   = (cur_found | any)
                  ? DATA_WIDTH'(first_idx)
                  : '1;
        end
      end else begin
        valid_d = 1'b1;
        last_d  = in_last;
        vec_d   = (r & in_act) | (in_old & ~in_act);
      end
    end
  end

  // Register outputs and carry scan state across beats
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_found <= 1'b0;
      out_last  <= 1'b0;
      mode_q    <= MODE_FIRST;
      found_q   <= 1'b0;
      base_q    <= '0;
      idx_q     <= '0;
    end else begin
      out_valid <= valid_d;
      out_vec   <= vec_d;
      out_found <= found_d;
      out_last  <= last_d;
      if (in_valid) begin
        mode_q  <= cur_mode;
        found_q <= cur_found | any;
        base_q  <= cur_base + STEP;
        if (!cur_found && any) idx_q <= hit_idx;
      end
    end
  end

endmodule

// File: tb/tb_vmask_first_scan.sv
// Bench for vmask_first_scan: directed cases plus random
// operations against an element-by-element reference model.
module tb_vmask_first_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_start, in_last;
  logic [1:0]  in_mode;
  logic [63:0] in_m0, in_act, in_old;
  logic        out_valid, out_found, out_last;
  logic [63:0] out_vec;

  int total = 0;
  int bad   = 0;

  // model state: element-level view of the running operation
  bit          m_seen;
  int          m_cnt;
  int          m_mode;
  int          m_first;

  localparam logic [63:0] ONES = '1;

  always #5 clk = ~clk;

  vmask_first_scan #(.DATA_WIDTH(64), .IDX_BITS(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_start(in_start), .in_last(in_last),
    .in_mode(in_mode), .in_m0(in_m0), .in_act(in_act),
    .in_old(in_old),
    .out_valid(out_valid), .out_vec(out_vec),
    .out_found(out_found), .out_last(out_last)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_seen = 0; m_cnt = 0; m_mode = 0; m_first = 0;
  endtask

  task automatic beat(input logic v, input logic s, input logic l,
                      input logic [1:0] md, input logic [63:0] m0,
                      input logic [63:0] act, input logic [63:0] old);
    logic [63:0] e, r, ev;
    logic evld, efnd, elst;
    in_valid = v; in_start = s; in_last = l; in_mode = md;
    in_m0 = m0; in_act = act; in_old = old;
    evld = 0; efnd = 0; elst = 0; ev = '0; r = '0;
    if (v) begin
      e = m0 & act;
      if (s) begin m_seen = 0; m_cnt = 0; m_mode = md; end
      for (int j = 0; j < 64; j++) begin
        case (m_mode)
          1: r[j] = !m_seen && !e[j];
          2: r[j] = !m_seen;
          3: r[j] = !m_seen && e[j];
          default: r[j] = 1'b0;
        endcase
        if (e[j] && !m_seen) begin
          m_seen  = 1;
          m_first = (m_cnt + j) % 1024;
        end
      end
      m_cnt = (m_cnt + 64) % 1024;
      if (m_mode == 0) begin
        if (l) begin
          evld = 1; elst = 1; efnd = m_seen;
          ev = m_seen ? 64'(m_first) : ONES;
        end
      end else begin
        evld = 1; elst = l;
        ev = (r & act) | (old & ~act);
      end
    end
    @(posedge clk); #1;
    chk("valid", 64'(out_valid), 64'(evld));
    chk("last", 64'(out_last), 64'(elst));
    chk("found", 64'(out_found), 64'(efnd));
    if (evld || !v) chk("vec", out_vec, ev);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'($urandom_range(0, 1));
    in_start = 1'b1; in_last = 1'b1;
    in_m0 = ONES; in_act = ONES;
    @(posedge clk); #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_vec", out_vec, 64'd0);
    chk("rst_found", 64'(out_found), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    model_reset();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] pat();
    case ($urandom_range(0, 4))
      0, 1: return 64'd0;
      2: return 64'd1 << $urandom_range(0, 63);
      3: return rnd64() & rnd64() & rnd64();
      default: return rnd64();
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 0; in_start = 0; in_last = 0;
    in_mode = 0; in_m0 = 0; in_act = 0; in_old = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // single-beat FIRST
    beat(1, 1, 1, 0, 64'h0100_0000, ONES, 0);
    chk("t1_vec", out_vec, 64'd24);
    // three-beat FIRST, hit in the second beat
    beat(1, 1, 0, 0, 64'd0, ONES, 0);
    beat(1, 0, 0, 0, 64'd1 << 5, ONES, 0);
    beat(1, 0, 1, 0, 64'd1, ONES, 0);
    chk("t2_vec", out_vec, 64'd69);
    // nothing found, then base restarts
    beat(1, 1, 0, 0, 64'd0, ONES, 0);
    beat(1, 0, 1, 0, 64'd0, ONES, 0);
    chk("t3_none", out_vec, ONES);
    beat(1, 1, 1, 0, 64'h8, ONES, 0);
    chk("t3_vec", out_vec, 64'd3);
    // SIF and SBF across two beats
    beat(1, 1, 0, 2, 64'h10, ONES, 0);
    chk("t4_sif0", out_vec, 64'h1F);
    beat(1, 0, 1, 2, 64'h1, ONES, 0);
    chk("t4_sif1", out_vec, 64'h0);
    beat(1, 1, 0, 1, 64'h10, ONES, 0);
    chk("t4_sbf0", out_vec, 64'h0F);
    beat(1, 0, 1, 1, 64'h1, ONES, 0);
    chk("t4_sbf1", out_vec, 64'h0);
    // SOF with an inactive element kept from old vd
    beat(1, 1, 1, 3, 64'h6, 64'hFFFF_FFFF_FFFF_FFFD, 64'h2);
    chk("t5_sof", out_vec, 64'h6);
    // reset in the middle of an SBF operation
    beat(1, 1, 0, 1, 64'h8, ONES, 0);
    do_reset();
    beat(1, 1, 1, 0, 64'd0, ONES, 0);
    chk("t6_vec", out_vec, ONES);
    // non-start beat right after reset runs as FIRST from base 0
    do_reset();
    beat(1, 0, 1, 2, 64'h8, ONES, 0);
    chk("t7_vec", out_vec, 64'd3);
    beat(0, 0, 0, 0, 0, 0, 0);

    // random operations, some aborted, long ones wrap the index
    for (int op = 0; op < 300; op++) begin
      int len;
      logic [1:0] md;
      md  = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        logic [63:0] act;
        if ($urandom_range(0, 5) == 0) beat(0, 0, 0, 0, rnd64(), 0, 0);
        act = ($urandom_range(0, 1) == 0) ? ONES : (rnd64() | rnd64());
        beat(1, b == 0, b == len - 1, md, pat(), act, rnd64());
        if (b > 0 && $urandom_range(0, 29) == 0) break;
      end
      if ($urandom_range(0, 39) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
